// File: rtl/program_counter_if.sv
// Fetch-side bus of the program counter: run control and branch inputs
// in, fetch address and status out. The master side drives the controls;
// the slave side is the counter itself.
interface program_counter_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          start;
  logic [1:0]    prog_sel;
  logic          branch_en;
  logic [D-1:0]  target;
  logic          stall;
  logic          halt;
  logic [D-1:0]  pc;
  logic          running;
  logic          done;
  logic [CW-1:0] cycle_cnt;

  modport master (
    output start, prog_sel, branch_en, target, stall, halt,
    input  pc, running, done, cycle_cnt
  );

  modport slave (
    input  start, prog_sel, branch_en, target, stall, halt,
    output pc, running, done, cycle_cnt
  );
endinterface

// File: rtl/program_counter.sv
// Registered program counter with IDLE/RUN/DONE run control.
// Loads one of three start addresses on a valid start, then steps,
// branches by a signed offset, or holds on stall. Halt freezes the PC and
// raises done. A saturating counter tracks RUN cycles since the last start.
module program_counter #(
  parameter int          D        = 12,
  parameter logic [11:0] P1_START = 12'd0,
  parameter logic [11:0] P2_START = 12'd0,
  parameter logic [11:0] P3_START = 12'd0,
  parameter int          CW       = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  program_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [D-1:0]  PC_ONE  = {{(D-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [1:0]    SEL_BAD = 2'd3;

  state_e        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic          start_ok_s;

  // Start address for a program select; select 3 is filtered out before use.
  function automatic logic [D-1:0] start_addr(input logic [1:0] sel);
    logic [D-1:0] addr;
    case (sel)
      2'd0:    addr = D'(P1_START);
      2'd1:    addr = D'(P2_START);
      2'd2:    addr = D'(P3_START);
      default: addr = D'(P3_START);
    endcase
    return addr;
  endfunction

  assign start_ok_s = bus.start && (bus.prog_sel != SEL_BAD);

  // Next-state, next-PC and next-count selection.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cycle_cnt_d = cycle_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok_s) begin
          state_d     = ST_RUN;
          pc_d        = start_addr(bus.prog_sel);
          cycle_cnt_d = {CW{1'b0}};
        end else begin
          state_d     = state_q;
        end
      end
      ST_RUN: begin
        if (cycle_cnt_q != CNT_MAX) begin
          cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        end else begin
          cycle_cnt_d = cycle_cnt_q;
        end
        // halt > stall > branch > sequential; D-bit adds drop the carry
        if (bus.halt) begin
          state_d = ST_DONE;
          pc_d    = pc_q;
        end else if (bus.stall) begin
          pc_d    = pc_q;
        end else if (bus.branch_en) begin
          pc_d    = pc_q + bus.target;
        end else begin
          pc_d    = pc_q + PC_ONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        pc_d        = {D{1'b0}};
        cycle_cnt_d = {CW{1'b0}};
      end
    endcase
  end

  // State, PC and cycle counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= {D{1'b0}};
      cycle_cnt_q <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: doc/program_counter.md
# program_counter

Registered program counter that sits directly downstream of the branch-target logic. It consumes the signed D-bit offset that logic produces, and presents the current fetch address to instruction memory. A small run-control state machine covers the rest of the counter's life: it loads one of three program start addresses on a start pulse, advances or branches each cycle, honours stalls, and stops on halt with a done flag. A saturating cycle counter supports per-program performance measurement.

## Interface
- D, 12, width of PC and of the incoming branch offset
- P1_START, 12'd0, start address of program 1
- P2_START, 12'd0, start address of program 2
- P3_START, 12'd0, start address of program 3
- CW, 16, width of cycle counter

Ports:
- Clk  input  1  the single clock; all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- start  input  1  begin executing the program selected by prog_sel
- prog_sel  input  2  0 = P1, 1 = P2, 2 = P3, 3 = invalid
- branch_en  input  1  take branch this cycle
- target  input  D  signed two's-complement PC offset from branch-target logic
- stall  input  1  hold PC this cycle
- halt  input  1  current instruction is a halt
- pc  output  D  current fetch address (registered)
- running  output  1  high while in RUN
- done  output  1  high while in DONE
- cycle_cnt  output  CW  RUN cycles elapsed since last start, saturating

## Operation
- States: IDLE, RUN, DONE. Encoding is free; outputs are decoded from registered state.
- Reset value of every output, and the state after reset: state = IDLE, pc = 0, running = 0, done = 0, cycle_cnt = 0.
- Reset asserted mid-operation returns to IDLE immediately (asynchronously), from any state.
- IDLE:
  - start = 1 with prog_sel in 0..2: pc ← selected Px_START, cycle_cnt ← 0, go to RUN.
  - start = 1 with prog_sel = 3: ignored, remain in IDLE, pc unchanged.
- RUN: cycle_cnt increments every cycle, saturating at 2^CW−1. PC update priority is halt > stall > branch_en > sequential:
  - halt = 1: pc holds, go to DONE (branch_en and stall ignored).
  - stall = 1: pc holds.
  - branch_en = 1: pc ← pc + target, modulo 2^D. target is signed.
  - otherwise: pc ← pc + 1, modulo 2^D.
  - start is ignored in RUN.
- DONE:
  - pc and cycle_cnt hold.
  - start with a valid prog_sel behaves exactly as in IDLE (reload, clear count, enter RUN).
  - start with prog_sel = 3 is ignored.
- Arithmetic rules:
  - Addition is D bits wide, carry discarded.
  - 4095 + 1 wraps to 0; 0 + (−1) wraps to 4095.
  - branch_en with target = 0 holds pc (the branch logic's "hold" value); it is still counted as a RUN cycle.
- Inputs branch_en, target, stall and halt are don't-care outside RUN.

## Timing
- Everything is registered; no combinational path from inputs to pc, running, done or cycle_cnt.
- start sampled at edge N: pc = Px_START and running = 1 after edge N, so the first fetch happens in cycle N+1.
- halt sampled at edge N: running = 0 and done = 1 after edge N. pc still shows the halt instruction's address.
- cycle_cnt after halt equals the number of edges spent in RUN, including the edge that sampled halt.
- One PC update per edge. A branch taken at edge N is visible at pc immediately after edge N.

## Test plan
- Reset and start:
  - Stimulus: Reset_n low mid-RUN, then release.
  - Required: pc = 0, running = 0, done = 0, cycle_cnt = 0 immediately on assertion.
  - Stimulus: start with prog_sel = 1 and P2_START = 12'h100.
  - Required: pc = 0x100 one edge later, running = 1.
- Sequential and branch:
  - Stimulus: 3 plain cycles from 0x100, then branch_en with target = 12'hFFB (−5).
  - Required: pc goes 0x101, 0x102, 0x103, then 0x0FE.
  - Stimulus: branch with target = 12'h014.
  - Required: pc advances by 20.
- Priority:
  - Stimulus: halt, stall and branch_en all high at pc = 0x050.
  - Required: pc stays 0x050, done = 1 next cycle.
  - Stimulus: stall and branch_en both high.
  - Required: pc holds.
- Wrap-around:
  - Stimulus: pc = 0xFFF with a sequential step.
  - Required: pc = 0x000.
  - Stimulus: pc = 0x002 with branch target = 12'hF88 (−120).
  - Required: pc = 0xF8A.
- Cycle counter:
  - Stimulus: with CW = 4, run 20 cycles.
  - Required: cycle_cnt saturates at 15.
  - Stimulus: start from DONE.
  - Required: cycle_cnt resets to 0, done clears.
- Invalid select:
  - Stimulus: start with prog_sel = 3, in IDLE and again in DONE.
  - Required: no state change, pc unchanged.
  - Stimulus: start pulsed during RUN.
  - Required: ignored; pc continues its normal sequence.
